// File: rtl/svm_window_ctrl_pkg.sv
// rtl/svm_window_ctrl_pkg.sv - shared SVM fixed-point widths and window FSM state encoding
package svm_window_ctrl_pkg;

  localparam int DEF_FEA_I = 4;
  localparam int DEF_FEA_F = 28;
  localparam int DEF_FEA_N = DEF_FEA_I + DEF_FEA_F;
  localparam int N_BINS    = 36;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FIRE   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/svm_pe.sv
// rtl/svm_pe.sv - 36-bin fixed-point MAC; o_data = i_data + sum(fea*coef >>> FEA_F), one cycle later
// Results wrap at FEA_N bits; the window controller relies on this truncation.
module svm_pe
  import svm_window_ctrl_pkg::*;
#(
  parameter int FEA_I = DEF_FEA_I,
  parameter int FEA_F = DEF_FEA_F,
  localparam int FEA_N = FEA_I + FEA_F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BINS*FEA_N-1:0] fea,
  input  logic [N_BINS*FEA_N-1:0] coef,
  input  logic [FEA_N-1:0]        i_data,
  input  logic                    i_valid,
  output logic [FEA_N-1:0]        o_data
);

  localparam int PW = 2 * FEA_N;

  logic signed [PW-1:0] prod;
  logic [FEA_N-1:0]     sum_d;
  logic [FEA_N-1:0]     o_data_q;

  always_comb begin
    sum_d = i_data;
    prod  = '0;
    for (int k = 0; k < N_BINS; k++) begin
      prod  = PW'($signed(fea[k*FEA_N +: FEA_N])) * PW'($signed(coef[k*FEA_N +: FEA_N]));
      sum_d = sum_d + FEA_N'(prod >>> FEA_F);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data_q <= '0;
    end else if (i_valid) begin
      o_data_q <= sum_d;
    end
  end

  assign o_data = o_data_q;

endmodule

// File: rtl/svm_window_ctrl.sv
// rtl/svm_window_ctrl.sv - sequences one detection window through svm_pe, block by block
// Feature/coef pairs are latched on fea_rvalid, fed to the PE, and the running sum returned.
module svm_window_ctrl
  import svm_window_ctrl_pkg::*;
#(
  parameter int FEA_I  = DEF_FEA_I,
  parameter int FEA_F  = DEF_FEA_F,
  parameter int N_BLK  = 105,
  parameter int ADDR_W = 7,
  localparam int FEA_N = FEA_I + FEA_F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FEA_N-1:0]        bias,
  output logic                    fea_req,
  output logic [ADDR_W-1:0]       fea_addr,
  input  logic                    fea_rvalid,
  input  logic [N_BINS*FEA_N-1:0] fea_rdata,
  output logic [ADDR_W-1:0]       coef_addr,
  input  logic [N_BINS*FEA_N-1:0] coef_rdata,
  output logic [N_BINS*FEA_N-1:0] pe_fea,
  output logic [N_BINS*FEA_N-1:0] pe_coef,
  output logic [FEA_N-1:0]        pe_i_data,
  output logic                    pe_i_valid,
  input  logic [FEA_N-1:0]        pe_o_data,
  output logic                    busy,
  output logic                    o_valid,
  output logic [FEA_N-1:0]        o_score,
  output logic                    o_detect
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [FEA_N-1:0]        acc_q, acc_d;
  logic [N_BINS*FEA_N-1:0] fea_q, fea_d;
  logic [N_BINS*FEA_N-1:0] coef_q, coef_d;
  logic [FEA_N-1:0]        score_q, score_d;
  logic                    detect_q, detect_d;
  logic                    last_blk;
  logic                    acc_pos;

  assign last_blk = (idx_q == ADDR_W'(N_BLK - 1));
  assign acc_pos  = !acc_q[FEA_N-1] && (|acc_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    fea_d    = fea_q;
    coef_d   = coef_q;
    score_d  = score_q;
    detect_d = detect_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          acc_d   = bias;
          state_d = ST_REQ;
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (fea_rvalid) begin
          fea_d   = fea_rdata;
          coef_d  = coef_rdata;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        acc_d = pe_o_data;
        if (last_blk) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        score_d  = acc_q;
        detect_d = acc_pos;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      fea_q    <= '0;
      coef_q   <= '0;
      score_q  <= '0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      fea_q    <= fea_d;
      coef_q   <= coef_d;
      score_q  <= score_d;
      detect_q <= detect_d;
    end
  end

  // Result is presented straight from acc during DONE so it changes exactly at DONE.
  assign o_valid    = (state_q == ST_DONE);
  assign o_score    = o_valid ? acc_q : score_q;
  assign o_detect   = o_valid ? acc_pos : detect_q;
  assign busy       = (state_q != ST_IDLE);
  assign fea_req    = (state_q == ST_REQ);
  assign fea_addr   = idx_q;
  assign coef_addr  = idx_q;
  assign pe_fea     = fea_q;
  assign pe_coef    = coef_q;
  assign pe_i_data  = acc_q;
  assign pe_i_valid = (state_q == ST_FIRE);

endmodule

// File: tb/tb_svm_window_ctrl.sv
// tb/tb_svm_window_ctrl.sv - window controller with svm_pe loopback, N_BLK=2
module tb_svm_window_ctrl;

  localparam int FN = 32;
  localparam int NB = 36;
  localparam int AW = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [FN-1:0]     bias;
  logic              fea_req;
  logic [AW-1:0]     fea_addr;
  logic              fea_rvalid;
  logic [NB*FN-1:0]  fea_rdata;
  logic [AW-1:0]     coef_addr;
  logic [NB*FN-1:0]  coef_rdata;
  logic [NB*FN-1:0]  pe_fea;
  logic [NB*FN-1:0]  pe_coef;
  logic [FN-1:0]     pe_i_data;
  logic              pe_i_valid;
  logic [FN-1:0]     pe_o_data;
  logic              busy;
  logic              o_valid;
  logic [FN-1:0]     o_score;
  logic              o_detect;

  logic [FN-1:0]     fea_word = '0;
  logic [FN-1:0]     coef_word = '0;
  int                rdelay = 1;
  int                rcnt = 0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  svm_window_ctrl #(.FEA_I(4), .FEA_F(28), .N_BLK(2), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .fea_req(fea_req), .fea_addr(fea_addr), .fea_rvalid(fea_rvalid), .fea_rdata(fea_rdata),
    .coef_addr(coef_addr), .coef_rdata(coef_rdata),
    .pe_fea(pe_fea), .pe_coef(pe_coef), .pe_i_data(pe_i_data), .pe_i_valid(pe_i_valid),
    .pe_o_data(pe_o_data), .busy(busy), .o_valid(o_valid), .o_score(o_score), .o_detect(o_detect)
  );

  svm_pe #(.FEA_I(4), .FEA_F(28)) u_pe (
    .clk(clk), .rst(rst), .fea(pe_fea), .coef(pe_coef),
    .i_data(pe_i_data), .i_valid(pe_i_valid), .o_data(pe_o_data)
  );

  // Feature memory answers rdelay cycles after fea_req; coef ROM is a plain 1-cycle register.
  always @(posedge clk) begin
    if (fea_req) rcnt <= rdelay;
    else if (rcnt > 0) rcnt <= rcnt - 1;
    coef_rdata <= {NB{coef_word}};
  end
  assign fea_rvalid = (rcnt == 1);
  assign fea_rdata  = {NB{fea_word}};

  typedef struct {
    logic [FN-1:0] bias;
    logic [FN-1:0] fea;
    logic [FN-1:0] coef;
    int            delay;
    bit            repulse;
    int            lat;
    logic [FN-1:0] score;
    logic          det;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_fea_req"}, 64'(fea_req), 0);
    check({tag, "_pe_i_valid"}, 64'(pe_i_valid), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_o_valid"}, 64'(o_valid), 0);
    check({tag, "_o_detect"}, 64'(o_detect), 0);
    check({tag, "_o_score"}, 64'(o_score), 0);
    check({tag, "_pe_i_data"}, 64'(pe_i_data), 0);
    check({tag, "_pe_fea_nz"}, 64'(|pe_fea), 0);
    check({tag, "_pe_coef_nz"}, 64'(|pe_coef), 0);
    check({tag, "_coef_addr"}, 64'(coef_addr), 0);
  endtask

  task automatic run_window(input vec_t v, input string tag);
    int lat, nval;
    bit bad_order, prev_rv, held, busy_ok;
    logic [FN-1:0] sc;
    logic det;
    bias = v.bias; fea_word = v.fea; coef_word = v.coef; rdelay = v.delay;
    lat = -1; nval = 0; bad_order = 0; prev_rv = 0; held = 1; busy_ok = 1; sc = '0; det = 0;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (pe_i_valid && !prev_rv) bad_order = 1;
      prev_rv = fea_rvalid;
      if (o_valid) begin
        nval++;
        if (lat < 0) begin lat = c; sc = o_score; det = o_detect; end
      end else if (lat >= 0 && (o_score !== sc || o_detect !== det)) begin
        held = 0;
      end
      if ((lat < 0 || c == lat) ? (busy !== 1'b1) : (busy !== 1'b0)) busy_ok = 0;
      start = v.repulse && (c == 3 || c == 8);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_score"}, 64'(sc), 64'(v.score));
    check({tag, "_detect"}, 64'(det), 64'(v.det));
    check({tag, "_n_valid"}, 64'(nval), 1);
    check({tag, "_pe_after_rvalid"}, 64'(bad_order), 0);
    check({tag, "_result_held"}, 64'(held), 1);
    check({tag, "_busy_window"}, 64'(busy_ok), 1);
  endtask

  initial begin
    int nval;
    vecs[0] = '{32'h10000000, 32'h00000000, 32'h00000000, 1, 1'b0, 9,  32'h10000000, 1'b1};
    vecs[1] = '{32'hF0000000, 32'h00000000, 32'h00000000, 1, 1'b0, 9,  32'hF0000000, 1'b0};
    vecs[2] = '{32'h00000000, 32'h10000000, 32'h02000000, 1, 1'b0, 9,  32'h90000000, 1'b0};
    vecs[3] = '{32'h00000000, 32'h10000000, 32'h02000000, 5, 1'b0, 17, 32'h90000000, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000000, 32'h00000000, 1, 1'b1, 9,  32'h00000000, 1'b0};
    vecs[5] = '{32'hF0000000, 32'h10000000, 32'h00400000, 1, 1'b0, 9,  32'h02000000, 1'b1};
    vecs[6] = '{32'h00000000, 32'hF0000000, 32'h02000000, 1, 1'b0, 9,  32'h70000000, 1'b1};
    vecs[7] = '{32'h10000000, 32'h00000000, 32'h00000000, 1, 1'b1, 9,  32'h10000000, 1'b1};

    rst = 1'b0; start = 1'b0; bias = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_window(vecs[i], $sformatf("vec%0d", i));

    // Abort during the second block's WAIT (cycle 6 with a 1-cycle memory).
    bias = 32'h10000000; fea_word = 32'h10000000; coef_word = 32'h02000000; rdelay = 1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midwin_busy_before_rst", 64'(busy), 1);
    rst = 1'b0;
    #1;
    check_quiet("midwin_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nval = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid) nval++;
    end
    check("midwin_no_valid", 64'(nval), 0);
    run_window(vecs[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/svm_window_ctrl.md
SVM_WINDOW_CTRL -- requirements
Module: svm_window_ctrl

Interface
REQ-001 The block SHALL have parameter FEA_I, default 4, meaning integer bits of a fixed-point feature or coefficient.
REQ-002 The block SHALL have parameter FEA_F, default 28, meaning fractional bits; FEA_N = FEA_I + FEA_F.
REQ-003 The block SHALL have parameter N_BLK, default 105, meaning number of 2x2-cell blocks per detection window.
REQ-004 The block SHALL have parameter ADDR_W, default 7, meaning block index width (2^ADDR_W >= N_BLK).
REQ-005 The block SHALL use one clock and an asynchronous active-low reset, with ports ordered as below.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- start  in  1  start-of-window pulse.
- bias  in  FEA_N  signed SVM bias, two's complement, sampled on accepted start.
- fea_req  out  1  one-cycle feature read request.
- fea_addr  out  ADDR_W  block index of the request.
- fea_rvalid  in  1  feature read data valid.
- fea_rdata  in  36*FEA_N  four cells x 9 bins; cell a at LSBs, then b, c, d.
- coef_addr  out  ADDR_W  coefficient ROM address.
- coef_rdata  in  36*FEA_N  coefficients, same packing; valid 1 cycle after coef_addr.
- pe_fea  out  36*FEA_N  registered PE feature operands.
- pe_coef  out  36*FEA_N  registered PE coefficient operands.
- pe_i_data  out  FEA_N  partial sum to the PE.
- pe_i_valid  out  1  PE accumulate strobe.
- pe_o_data  in  FEA_N  PE result, valid 1 cycle after pe_i_valid.
- busy  out  1  high from accepted start until the DONE cycle inclusive.
- o_valid  out  1  one-cycle result strobe.
- o_score  out  FEA_N  final signed score.
- o_detect  out  1  person detected.

Function
REQ-006 The FSM SHALL have states IDLE, REQ, WAIT, FIRE, SETTLE and DONE.
REQ-007 In IDLE, a start pulse SHALL set idx=0 and acc=bias, then go to REQ; start in any other state SHALL be ignored.
REQ-008 REQ SHALL assert fea_req for exactly one cycle with fea_addr=idx, then go to WAIT.
REQ-009 coef_addr SHALL equal idx in every state.
REQ-010 WAIT SHALL hold until fea_rvalid=1, with no timeout; in that cycle pe_fea SHALL capture fea_rdata, pe_coef SHALL capture coef_rdata, and the FSM SHALL go to FIRE.
REQ-011 fea_rvalid SHALL be ignored outside WAIT.
REQ-012 FIRE SHALL drive pe_i_valid=1 for one cycle with pe_i_data=acc, then go to SETTLE.
REQ-013 SETTLE SHALL load acc with pe_o_data.
REQ-014 From SETTLE, if idx==N_BLK-1 the FSM SHALL go to DONE; otherwise it SHALL increment idx and go to REQ. idx SHALL never wrap.
REQ-015 DONE SHALL pulse o_valid for one cycle with o_score=acc and o_detect=1 iff acc is signed and strictly greater than zero, then go to IDLE.
REQ-016 o_score and o_detect SHALL hold their values until the next DONE.
REQ-017 The controller SHALL perform no arithmetic on scores; overflow behaviour is the PE's truncation.
REQ-018 With fea_rvalid returned one cycle after fea_req, each block SHALL take 4 cycles, and o_valid SHALL assert 4*N_BLK+1 cycles after the start cycle.
REQ-019 pe_i_valid SHALL be 0 in every state except FIRE.

Reset
REQ-020 While rst=0, the FSM SHALL be IDLE and idx, acc, pe_fea, pe_coef, o_score SHALL be 0.
REQ-021 While rst=0, fea_req, pe_i_valid, busy, o_valid and o_detect SHALL be 0.
REQ-022 Reset asserted mid-window SHALL abandon the window with no o_valid; a later start SHALL produce a correct result.

Structure
REQ-023 FEA_I, FEA_F, FEA_N and the state encodings SHALL live in the shared SVM definitions header, used by this block and svm_pe.
REQ-024 The block SHALL be a single module with no sub-modules; svm_pe SHALL be instantiated beside it by the parent.

Verification
REQ-025 The bench SHALL connect svm_pe in loopback with N_BLK=2, a 1-cycle feature memory and a 1-cycle coefficient ROM.
REQ-026 Zero features, bias=0x10000000 -> o_valid 9 cycles after start, o_score=0x10000000, o_detect=1.
REQ-027 Zero features, bias=0xF0000000 -> o_score=0xF0000000, o_detect=0; all bins 0x10000000, all coefs 0x02000000, bias 0 -> o_score=0x90000000 (PE truncation), o_detect=0.
REQ-028 fea_rvalid delayed 5 cycles per block -> pe_i_valid only after each rvalid, o_valid at cycle 17, same score as the 1-cycle case.
REQ-029 bias=0 with zero features -> o_score=0, o_detect=0; start re-pulsed while busy=1 -> ignored, exactly one o_valid.
REQ-030 rst dropped during the second block's WAIT -> all outputs 0, no o_valid; a fresh start then gives the REQ-026 result.
